multu_hilo: RTL

//  Sequential 32x32 unsigned shift-add multiplier with HI/LO result registers.

---
 rtl/multu_hilo.sv | 122 ++++++++++++
 1 files changed

// File: rtl/multu_hilo.sv
// ---------------------------------------------------------------------------
// multu_hilo
//   Sequential WIDTH x WIDTH unsigned shift-add multiplier with HI/LO result
//   registers.
//
//   The ALU control drives a 6-bit control word into this block:
//     - MUL starts a multiply.
//     - HILO_OPEN commits the finished product to HI/LO.
//     - MFHI and MFLO read HI or LO back onto dataOut.
//
//   Ports:
//     clk      in   1      clock, rising edge
//     reset    in   1      asynchronous, active-high reset
//     dataA    in   WIDTH  multiplicand, sampled on the start edge only
//     dataB    in   WIDTH  multiplier, sampled on the start edge only
//     Signal   in   6      control word from ALU control
//     dataOut  out  WIDTH  HI on MFHI, LO on MFLO, else 0 (combinational)
//     busy     out  1      high while iterating
//     done     out  1      product ready, waiting for HILO_OPEN
//
//   Control handshake:
//     Signal is a level-sensitive command sampled on every rising edge.
//     - A MUL command is accepted only in IDLE.
//     - A HILO_OPEN command is accepted only in DONE.
//     - In every other state, both commands are ignored.
//     The controller may therefore hold MUL for the whole iteration count
//     without causing a restart.
//     busy and done together expose the FSM state:
//       00 = IDLE, 10 = BUSY, 01 = DONE.
// ---------------------------------------------------------------------------
module multu_hilo #(
  parameter int          WIDTH     = 32,
  parameter logic [5:0]  MUL       = 6'b011001,
  parameter logic [5:0]  MFHI      = 6'b010000,
  parameter logic [5:0]  MFLO      = 6'b010010,
  parameter logic [5:0]  HILO_OPEN = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;   // upper half: accumulator, lower half: multiplier
  logic [5:0]         count;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  // One iteration:
  //   - Add the multiplicand to the accumulator when the current multiplier
  //     LSB is set.
  //   - Keep the carry, because it shifts into the product MSB.
  logic [WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      prod  <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Signal == MUL) begin
            mcand <= dataA;
            prod  <= {{WIDTH{1'b0}}, dataB};
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          prod  <= {sum, prod[WIDTH-1:1]};
          count <= count + 6'd1;
          if (count == 6'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Only HILO_OPEN can release DONE.
          // A held MUL must not restart the multiply.
          if (Signal == HILO_OPEN) begin
            hi    <= prod[2*WIDTH-1:WIDTH];
            lo    <= prod[WIDTH-1:0];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  // Reads only ever see committed HI/LO, never the in-flight product.
  always_comb begin
    dataOut = '0;
    if (Signal == MFHI) begin
      dataOut = hi;
    end else if (Signal == MFLO) begin
      dataOut = lo;
    end
  end

endmodule
